// File: rtl/drive_pkg.sv
// Shared types and constants for the driver-input front end.
// Gear width, gear limits, repeat-FSM states and counter width.
package drive_pkg;

   localparam int GEAR_W       = 3;
   localparam int MIN_GEAR_DEF = 1;
   localparam int MAX_GEAR_DEF = 6;
   localparam int CNT_W        = 25;

   typedef enum logic [1:0] {
      RPT_IDLE,
      RPT_DELAY,
      RPT_REPEAT
   } rpt_state_e;

endpackage

// File: rtl/btn_debounce.sv
// Two-flop synchroniser, stability counter and rise detect
// for one raw push-button.
module btn_debounce #(
   parameter int DEBOUNCE_CYCLES = 250000
) (
   input  logic clk,
   input  logic rst,
   input  logic raw,
   output logic level,
   output logic rise
);

   localparam int CW = $clog2(DEBOUNCE_CYCLES);
   localparam logic [CW-1:0] LAST = CW'(DEBOUNCE_CYCLES - 1);

   logic          s1_q;
   logic          s2_q;
   logic          lvl_q;
   logic          lvl_d;
   logic          prev_q;
   logic [CW-1:0] cnt_q;
   logic [CW-1:0] cnt_d;

   always_comb begin
      lvl_d = lvl_q;
      cnt_d = '0;
      if (s2_q != lvl_q) begin
         if (cnt_q == LAST) begin
            lvl_d = s2_q;
         end else begin
            cnt_d = cnt_q + 1'b1;
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         s1_q   <= 1'b0;
         s2_q   <= 1'b0;
         lvl_q  <= 1'b0;
         prev_q <= 1'b0;
         cnt_q  <= '0;
      end else begin
         s1_q   <= raw;
         s2_q   <= s1_q;
         lvl_q  <= lvl_d;
         prev_q <= lvl_q;
         cnt_q  <= cnt_d;
      end
   end

   assign level = lvl_q;
   assign rise  = lvl_q & ~prev_q;

endmodule

// File: rtl/drive_input_ctrl.sv
// Driver-input front end: debounced buttons, accel/brake
// hold-to-repeat pulses and the registered gear selection.
module drive_input_ctrl
   import drive_pkg::*;
#(
   parameter int DEBOUNCE_CYCLES = 250000,
   parameter int REPEAT_DELAY    = 25000000,
   parameter int REPEAT_PERIOD   = 5000000,
   parameter int MIN_GEAR        = MIN_GEAR_DEF,
   parameter int MAX_GEAR        = MAX_GEAR_DEF
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              btn_accel,
   input  logic              btn_brake,
   input  logic              btn_gear_up,
   input  logic              btn_gear_dn,
   output logic              accel_pulse,
   output logic              decel_pulse,
   output logic [GEAR_W-1:0] gear,
   output logic              shift_reject
);

   localparam logic [CNT_W-1:0] RD1 =
      CNT_W'(REPEAT_DELAY - 1);
   localparam logic [CNT_W-1:0] RP1 =
      CNT_W'(REPEAT_PERIOD - 1);
   localparam logic [GEAR_W-1:0] GMIN =
      GEAR_W'(MIN_GEAR);
   localparam logic [GEAR_W-1:0] GMAX =
      GEAR_W'(MAX_GEAR);

   logic db_accel, rise_accel;
   logic db_brake, rise_brake;
   logic db_up, rise_up;
   logic db_dn, rise_dn;

   btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_accel (
      .clk   (clk),
      .rst   (rst),
      .raw   (btn_accel),
      .level (db_accel),
      .rise  (rise_accel)
   );

   btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_brake (
      .clk   (clk),
      .rst   (rst),
      .raw   (btn_brake),
      .level (db_brake),
      .rise  (rise_brake)
   );

   btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_up (
      .clk   (clk),
      .rst   (rst),
      .raw   (btn_gear_up),
      .level (db_up),
      .rise  (rise_up)
   );

   btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_dn (
      .clk   (clk),
      .rst   (rst),
      .raw   (btn_gear_dn),
      .level (db_dn),
      .rise  (rise_dn)
   );

   // Index 0 is accel, index 1 is brake.
   rpt_state_e       st_q [2];
   rpt_state_e       st_d [2];
   logic [CNT_W-1:0] cnt_q [2];
   logic [CNT_W-1:0] cnt_d [2];
   logic [1:0]       pls_q;
   logic [1:0]       pls_d;
   logic [1:0]       hold;
   logic [1:0]       start;
   logic             brk_prev_q;

   // A held accel after brake release restarts as a fresh press.
   assign hold[0]  = db_accel & ~db_brake;
   assign hold[1]  = db_brake;
   assign start[0] = rise_accel | brk_prev_q;
   assign start[1] = rise_brake;

   always_comb begin
      for (int i = 0; i < 2; i++) begin
         st_d[i]  = st_q[i];
         cnt_d[i] = cnt_q[i];
         pls_d[i] = 1'b0;
         if (!hold[i]) begin
            st_d[i] = RPT_IDLE;
         end else begin
            unique case (st_q[i])
               RPT_IDLE: begin
                  if (start[i]) begin
                     pls_d[i] = 1'b1;
                     cnt_d[i] = RD1;
                     st_d[i]  = RPT_DELAY;
                  end
               end
               RPT_DELAY, RPT_REPEAT: begin
                  if (cnt_q[i] == '0) begin
                     pls_d[i] = 1'b1;
                     cnt_d[i] = RP1;
                     st_d[i]  = RPT_REPEAT;
                  end else begin
                     cnt_d[i] = cnt_q[i] - 1'b1;
                  end
               end
               default: st_d[i] = RPT_IDLE;
            endcase
         end
      end
   end

   logic [GEAR_W-1:0] gear_q;
   logic [GEAR_W-1:0] gear_d;
   logic              rej_q;
   logic              rej_d;

   always_comb begin
      gear_d = gear_q;
      rej_d  = 1'b0;
      unique case (1'b1)
         rise_up & rise_dn: rej_d = 1'b1;
         rise_up & ~rise_dn: begin
            if (gear_q < GMAX && !db_accel)
               gear_d = gear_q + 1'b1;
            else
               rej_d = 1'b1;
         end
         rise_dn & ~rise_up: begin
            if (gear_q > GMIN && !db_accel)
               gear_d = gear_q - 1'b1;
            else
               rej_d = 1'b1;
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < 2; i++) begin
            st_q[i]  <= RPT_IDLE;
            cnt_q[i] <= '0;
         end
         pls_q      <= '0;
         brk_prev_q <= 1'b0;
         gear_q     <= GMIN;
         rej_q      <= 1'b0;
      end else begin
         for (int i = 0; i < 2; i++) begin
            st_q[i]  <= st_d[i];
            cnt_q[i] <= cnt_d[i];
         end
         pls_q      <= pls_d;
         brk_prev_q <= db_brake;
         gear_q     <= gear_d;
         rej_q      <= rej_d;
      end
   end

   // Masking by the current levels drops a pulse whose button
   // debounced low, or brake engaged, on the same edge.
   assign accel_pulse  = pls_q[0] & db_accel & ~db_brake;
   assign decel_pulse  = pls_q[1] & db_brake;
   assign gear         = gear_q;
   assign shift_reject = rej_q;

endmodule
